// File: rtl/vga_sprite_ball_if.sv
// vga_sprite_ball_if: host register-write bus for the VGA sprite engine.
//   writedata  - 8-bit write data
//   write      - write strobe
//   chipselect - block select
//   address    - 3-bit register select
// master drives the bus (host), slave receives it (sprite engine).
interface vga_sprite_ball_if;
  logic [7:0] writedata;
  logic       write;
  logic       chipselect;
  logic [2:0] address;

  modport master (output writedata, output write, output chipselect, output address);
  modport slave  (input  writedata, input  write, input  chipselect, input  address);
endinterface

// File: rtl/vga_sprite_ball.sv
// vga_sprite_ball: 640x480 VGA timing from a 50 MHz clock (2 clk per pixel)
// with one 16x16 sprite of 4-bit colour indices over a background colour.
// Ports:
//   clk, reset           - clock, async active-high reset
//   bus (slave modport)  - host register writes (writedata/write/chipselect/address)
//   VGA_R/G/B            - 8-bit colour, registered, 0 outside the active area
//   VGA_CLK              - pixel clock, hcount[0]
//   VGA_HS/VGA_VS        - active-low syncs, registered
//   VGA_BLANK_n          - high inside the active area, registered
//   VGA_SYNC_n           - tied low
// Registers: addr0 attribute table (vpos/hpos/base via rotating pointer),
//   addr1 pattern pointer, addr2 pattern byte write, addr3 pointer reset.
// Optional macro VGA_SPRITE_BG_COLOR_EN: addr4 sets the background palette
//   index; without it addr4 is ignored and the background is black.
// RGB/HS/VS/BLANK_n all trail the counter state by exactly two clocks.
module vga_sprite_ball (
  input  logic                      clk,
  input  logic                      reset,
  vga_sprite_ball_if.slave          bus,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      VGA_CLK,
  output logic                      VGA_HS,
  output logic                      VGA_VS,
  output logic                      VGA_BLANK_n,
  output logic                      VGA_SYNC_n
);

  localparam int unsigned HACTIVE  = 1280;
  localparam int unsigned HFRONT   = 32;
  localparam int unsigned HSYNC    = 192;
  localparam int unsigned HBACK    = 96;
  localparam int unsigned HTOTAL   = HACTIVE + HFRONT + HSYNC + HBACK;
  localparam int unsigned VACTIVE  = 480;
  localparam int unsigned VFRONT   = 10;
  localparam int unsigned VSYNC    = 2;
  localparam int unsigned VBACK    = 33;
  localparam int unsigned VTOTAL   = VACTIVE + VFRONT + VSYNC + VBACK;
  localparam int unsigned HW       = 11;
  localparam int unsigned VW       = 10;
  localparam int unsigned HS_FIRST = HACTIVE + HFRONT;
  localparam int unsigned HS_LAST  = HACTIVE + HFRONT + HSYNC - 1;
  localparam int unsigned VS_FIRST = VACTIVE + VFRONT;
  localparam int unsigned VS_LAST  = VACTIVE + VFRONT + VSYNC - 1;

  // Fixed 16-entry palette; index 0 maps to black (transparent for the sprite).
  function automatic logic [23:0] palette(input logic [3:0] idx);
    logic [23:0] rgb;
    case (idx)
      4'd0:    rgb = 24'h000000;
      4'd1:    rgb = 24'hFFFF00;
      4'd2:    rgb = 24'hFF0000;
      4'd3:    rgb = 24'hFFB852;
      4'd4:    rgb = 24'h00FFFF;
      4'd5:    rgb = 24'hFFB8FF;
      4'd6:    rgb = 24'h2121FF;
      default: rgb = 24'hFFFFFF;
    endcase
    return rgb;
  endfunction

  // ---------------- timing counters ----------------
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q + HW'(1);
    vcount_d = vcount_q;
    if (hcount_q == HW'(HTOTAL - 1)) begin
      hcount_d = '0;
      vcount_d = (vcount_q == VW'(VTOTAL - 1)) ? '0 : vcount_q + VW'(1);
    end
  end

  // ---------------- register bus ----------------
  logic [7:0] vpos_q, vpos_d;
  logic [7:0] hpos_q, hpos_d;
  logic [7:0] base_q, base_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] gptr_q, gptr_d;
  logic       prev_wr_q;
  logic [2:0] prev_addr_q;
  logic [7:0] prev_data_q;
  logic       wr_c, accept_c, mem_we_c;
`ifdef VGA_SPRITE_BG_COLOR_EN
  logic [3:0] bg_idx_q, bg_idx_d;
`endif

  // A held strobe with unchanged address/data is one write, not many.
  assign wr_c     = bus.chipselect & bus.write;
  assign accept_c = wr_c & ~(prev_wr_q && (prev_addr_q == bus.address)
                             && (prev_data_q == bus.writedata));

  always_comb begin
    vpos_d   = vpos_q;
    hpos_d   = hpos_q;
    base_d   = base_q;
    ptr_d    = ptr_q;
    gptr_d   = gptr_q;
    mem_we_c = 1'b0;
`ifdef VGA_SPRITE_BG_COLOR_EN
    bg_idx_d = bg_idx_q;
`endif
    if (accept_c) begin
      case (bus.address)
        3'd0: begin
          case (ptr_q)
            2'd0:    vpos_d = bus.writedata;
            2'd1:    hpos_d = bus.writedata;
            default: base_d = bus.writedata;
          endcase
          ptr_d = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        end
        3'd1: gptr_d   = bus.writedata;
        3'd2: mem_we_c = 1'b1;
        3'd3: ptr_d    = 2'd0;
`ifdef VGA_SPRITE_BG_COLOR_EN
        3'd4: bg_idx_d = bus.writedata[3:0];
`endif
        default: ;
      endcase
    end
  end

  // ---------------- stage 1: sprite hit test and pattern fetch ----------------
  logic [9:0] x_c, y_c, dx_c, dy_c;
  logic       active_c, hit_c, hs_c, vs_c;
  logic [7:0] fetch_addr_c;

  assign x_c  = hcount_q[10:1];
  assign y_c  = vcount_q;
  assign dx_c = x_c - 10'(hpos_q);
  assign dy_c = y_c - 10'(vpos_q);

  assign active_c = (hcount_q < HW'(HACTIVE)) && (vcount_q < VW'(VACTIVE));
  // Unsigned compare plus 16-wide window: sprite clips at the edge, never wraps.
  assign hit_c    = (x_c >= 10'(hpos_q)) && (dx_c[9:4] == 6'd0)
                 && (y_c >= 10'(vpos_q)) && (dy_c[9:4] == 6'd0);
  assign fetch_addr_c = base_q + {1'b0, dy_c[3:0], 3'b000} + {5'b00000, dx_c[3:1]};
  assign hs_c = ~((hcount_q >= HW'(HS_FIRST)) && (hcount_q <= HW'(HS_LAST)));
  assign vs_c = ~((vcount_q >= VW'(VS_FIRST)) && (vcount_q <= VW'(VS_LAST)));

  logic [7:0] gen_mem [256];
  logic [7:0] s1_byte_q;
  logic       s1_active_q, s1_hit_q, s1_right_q, s1_hs_q, s1_vs_q;

  // Pattern RAM: synchronous write from the bus, registered pixel read.
  always_ff @(posedge clk) begin
    if (mem_we_c) gen_mem[gptr_q] <= bus.writedata;
    s1_byte_q <= gen_mem[fetch_addr_c];
  end

  // ---------------- stage 2: palette lookup ----------------
  logic [3:0]  idx_c;
  logic [23:0] bg_rgb_c, rgb_d, rgb_q;
  logic        hs_q, vs_q, blank_n_q;

  assign idx_c = s1_right_q ? s1_byte_q[3:0] : s1_byte_q[7:4];
`ifdef VGA_SPRITE_BG_COLOR_EN
  assign bg_rgb_c = palette(bg_idx_q);
`else
  assign bg_rgb_c = 24'h000000;
`endif

  always_comb begin
    rgb_d = 24'h000000;
    if (s1_active_q) rgb_d = (s1_hit_q && (idx_c != 4'd0)) ? palette(idx_c) : bg_rgb_c;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      vpos_q      <= '0;
      hpos_q      <= '0;
      base_q      <= '0;
      ptr_q       <= '0;
      gptr_q      <= '0;
      prev_wr_q   <= 1'b0;
      prev_addr_q <= '0;
      prev_data_q <= '0;
      s1_active_q <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_right_q  <= 1'b0;
      s1_hs_q     <= 1'b1;
      s1_vs_q     <= 1'b1;
      rgb_q       <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      blank_n_q   <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      vpos_q      <= vpos_d;
      hpos_q      <= hpos_d;
      base_q      <= base_d;
      ptr_q       <= ptr_d;
      gptr_q      <= gptr_d;
      prev_wr_q   <= wr_c;
      prev_addr_q <= bus.address;
      prev_data_q <= bus.writedata;
      s1_active_q <= active_c;
      s1_hit_q    <= hit_c;
      s1_right_q  <= dx_c[0];
      s1_hs_q     <= hs_c;
      s1_vs_q     <= vs_c;
      rgb_q       <= rgb_d;
      hs_q        <= s1_hs_q;
      vs_q        <= s1_vs_q;
      blank_n_q   <= s1_active_q;
    end
  end

`ifdef VGA_SPRITE_BG_COLOR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bg_idx_q <= '0;
    else       bg_idx_q <= bg_idx_d;
  end
`endif

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_n = blank_n_q;
  assign VGA_CLK     = hcount_q[0];
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_vga_sprite_ball.sv
// Bench for vga_sprite_ball: a cycle model of beam position, registers and
// pattern RAM queues the expected {RGB,HS,VS,BLANK_n} for every counter state;
// entries are popped two clocks later when the DUT shows them. Directed
// pixel checks use constant colours at chosen screen positions.
module tb_vga_sprite_ball;

  typedef logic [26:0] vec_t;
  localparam vec_t RST_VEC = {24'h000000, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_sprite_ball_if bus ();
  logic [7:0] vga_r, vga_g, vga_b;
  logic       vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  vga_sprite_ball dut (
    .clk(clk), .reset(rst), .bus(bus),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b), .VGA_CLK(vga_clk),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .VGA_BLANK_n(vga_blank_n), .VGA_SYNC_n(vga_sync_n)
  );

  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b1;
  int   n = 0;
  int   shown = -1;
  vec_t q[$];

  // Reference state
  logic [7:0]  m_mem [256];
  logic [7:0]  m_vpos, m_hpos, m_base, m_gptr;
  logic [1:0]  m_ptr;
  logic [3:0]  m_bg;
  bit          m_prev_v;
  logic [10:0] m_prev;

  function automatic logic [23:0] pal(input logic [3:0] i);
    case (i)
      4'd0: return 24'h000000;
      4'd1: return 24'hFFFF00;
      4'd2: return 24'hFF0000;
      4'd3: return 24'hFFB852;
      4'd4: return 24'h00FFFF;
      4'd5: return 24'hFFB8FF;
      4'd6: return 24'h2121FF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  function automatic logic [7:0] pat_byte(input int i);
    logic [7:0] pat [5];
    pat = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h55};
    if (i < 128) return pat[((i / 8) + 3) % 5];
    return 8'(i ^ 8'hA5);
  endfunction

  function automatic vec_t exp_vec(input int cnt);
    int hc, vc, x, dx, dy;
    logic [7:0] byt;
    logic [3:0] idx;
    logic [23:0] rgb;
    bit act, hs, vs;
    hc  = cnt % 1600;
    vc  = (cnt / 1600) % 525;
    x   = hc / 2;
    act = (hc < 1280) && (vc < 480);
    hs  = !((hc >= 1312) && (hc <= 1503));
    vs  = !((vc >= 490) && (vc <= 491));
    rgb = 24'h000000;
    if (act) begin
`ifdef VGA_SPRITE_BG_COLOR_EN
      rgb = pal(m_bg);
`endif
      dx = x - int'(m_hpos);
      dy = vc - int'(m_vpos);
      if (dx >= 0 && dx < 16 && dy >= 0 && dy < 16) begin
        byt = m_mem[(int'(m_base) + dy * 8 + dx / 2) % 256];
        idx = (dx % 2 == 0) ? byt[7:4] : byt[3:0];
        if (idx != 4'd0) rgb = pal(idx);
      end
    end
    return {rgb, hs, vs, act};
  endfunction

  // Monitor: bus inputs seen here are the ones the next rising edge latches.
  always @(negedge clk) begin : mon
    vec_t e, o;
    o = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n};
    if (rst) begin
      if (mon_en) begin
        vectors++;
        assert (o === RST_VEC) else begin
          miscompares++;
          $error("FAIL reset_out obs=%h exp=%h", o, RST_VEC);
        end
        vectors++;
        assert ({vga_sync_n, vga_clk} === 2'b00) else begin
          miscompares++;
          $error("FAIL reset_clk_sync obs=%b exp=00", {vga_sync_n, vga_clk});
        end
      end
      q.delete();
      n = 0; shown = -1;
      m_vpos = 0; m_hpos = 0; m_base = 0; m_gptr = 0; m_ptr = 0; m_bg = 0;
      m_prev_v = 1'b0; m_prev = '0;
    end else begin
      if (q.size() == 0) begin
        q.push_back(RST_VEC);
        q.push_back(RST_VEC);
      end
      q.push_back(exp_vec(n));
      if (bus.chipselect && bus.write && !(m_prev_v && m_prev == {bus.address, bus.writedata})) begin
        case (bus.address)
          3'd0: begin
            case (m_ptr)
              2'd0: m_vpos = bus.writedata;
              2'd1: m_hpos = bus.writedata;
              default: m_base = bus.writedata;
            endcase
            m_ptr = (m_ptr == 2'd2) ? 2'd0 : m_ptr + 2'd1;
          end
          3'd1: m_gptr = bus.writedata;
          3'd2: m_mem[m_gptr] = bus.writedata;
          3'd3: m_ptr = 2'd0;
`ifdef VGA_SPRITE_BG_COLOR_EN
          3'd4: m_bg = bus.writedata[3:0];
`endif
          default: ;
        endcase
      end
      m_prev_v = bus.chipselect && bus.write;
      m_prev   = {bus.address, bus.writedata};
      e = q.pop_front();
      if (mon_en) begin
        vectors++;
        assert (o === e) else begin
          miscompares++;
          $error("FAIL pixel_stream cnt=%0d obs=%h exp=%h", n - 2, o, e);
        end
        vectors++;
        assert ({vga_sync_n, vga_clk} === {1'b0, n[0]}) else begin
          miscompares++;
          $error("FAIL clk_sync cnt=%0d obs=%b exp=%b", n, {vga_sync_n, vga_clk}, {1'b0, n[0]});
        end
      end
      shown = n - 2;
      n++;
    end
  end

  task automatic bus_wr(input logic [2:0] a, input logic [7:0] d, input int hold);
    bus.chipselect = 1'b1; bus.write = 1'b1; bus.address = a; bus.writedata = d;
    repeat (hold) @(posedge clk);
    #2;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0; bus.write = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    bus.chipselect = 1'b0; bus.write = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Wait (bounded) until pixel (x,y) is on the pins, then check its colour.
  task automatic check_pix(input int x, input int y, input logic [23:0] exp, input string tag);
    int tgt, c;
    tgt = y * 1600 + 2 * x;
    c = 0;
    do begin
      @(negedge clk); #1; c++;
    end while (shown < tgt && c < 70000);
    vectors++;
    assert (shown == tgt && {vga_r, vga_g, vga_b} === exp) else begin
      miscompares++;
      $error("FAIL %s at (%0d,%0d) cnt=%0d obs=%h exp=%h", tag, x, y, shown, {vga_r, vga_g, vga_b}, exp);
    end
  endtask

  task automatic wait_hs(input logic level, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk); #1; cycles++;
    end while (vga_hs !== level && cycles < 4000);
  endtask

  localparam logic [23:0] BG_EXP =
`ifdef VGA_SPRITE_BG_COLOR_EN
    24'h2121FF;
`else
    24'h000000;
`endif

  initial begin
    int lo, hi, dummy;
    rst = 1'b1;
    bus.chipselect = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    mon_en = 1'b0;

    // Load the whole pattern RAM (its power-up content is not defined).
    for (int i = 0; i < 256; i++) begin
      bus_wr(3'd1, 8'(i), 1);
      bus_wr(3'd2, pat_byte(i), 1);
    end
    bus_idle();

    // Held writes collapse; fourth distinct write wraps to vpos.
    mon_en = 1'b1;
    do_reset();
    bus_wr(3'd0, 8'hC0, 3);
    bus_wr(3'd0, 8'hF1, 3);
    bus_wr(3'd0, 8'h02, 3);
    bus_idle();
    bus_wr(3'd0, 8'h01, 1);
    bus_wr(3'd5, 8'hFF, 1);
    bus_idle();
    check_pix(240, 1, 24'h000000, "left_of_sprite");
    check_pix(241, 1, 24'hFFB852, "sprite_origin");
    check_pix(242, 1, 24'hFFB852, "origin_col1");
    check_pix(241, 2, 24'hFFB8FF, "row1_col0");
    check_pix(255, 2, 24'h000000, "transparent_idx0");
    check_pix(241, 17, 24'h000000, "below_sprite");

    // Line timing.
    wait_hs(1'b0, dummy);
    wait_hs(1'b1, lo);
    wait_hs(1'b0, hi);
    vectors++;
    assert (lo == 192) else begin
      miscompares++;
      $error("FAIL hs_low_width obs=%0d exp=192", lo);
    end
    vectors++;
    assert (lo + hi == 1600) else begin
      miscompares++;
      $error("FAIL hs_period obs=%0d exp=1600", lo + hi);
    end

    // Nibble order, pointer reset, background register.
    do_reset();
    bus_wr(3'd1, 8'h40, 1);
    bus_wr(3'd2, 8'h12, 1);
    bus_wr(3'd0, 8'h01, 1);
    bus_wr(3'd0, 8'h0A, 1);
    bus_wr(3'd0, 8'h40, 1);
    bus_wr(3'd3, 8'h00, 1);
    bus_wr(3'd0, 8'h02, 1);
    bus_wr(3'd4, 8'h06, 1);
    bus_idle();
    check_pix(10, 1, BG_EXP, "ptr_reset_old_row");
    check_pix(10, 2, 24'hFFFF00, "nibble_high_left");
    check_pix(11, 2, 24'hFF0000, "nibble_low_right");
    check_pix(100, 4, BG_EXP, "background");

    // Right-edge clipping with hpos=255.
    do_reset();
    bus_wr(3'd0, 8'h00, 1);
    bus_wr(3'd0, 8'hFF, 1);
    bus_wr(3'd0, 8'h02, 1);
    bus_idle();
    check_pix(254, 0, 24'h000000, "clip_x254");
    check_pix(255, 0, 24'hFFB852, "clip_x255");
    check_pix(270, 0, 24'hFFB8FF, "clip_x270");
    check_pix(271, 0, 24'h000000, "clip_x271");
    check_pix(0, 1, 24'h000000, "no_wrap_x0");
    check_pix(15, 1, 24'h000000, "no_wrap_x15");
    check_pix(255, 15, 24'hFFB852, "clip_row15");
    check_pix(255, 16, 24'h000000, "clip_y16");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
